// File: rtl/bf_pkg.sv
// Shared definitions for the bf CPU: opcode bytes and the fetch/execute sequencer states.
// BF_SINGLE_STEP_EN adds the PAUSE state used for single-stepping.
package bf_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_LOOP  = 8'h5B;
    localparam logic [7:0] OP_END   = 8'h5D;
    localparam logic [7:0] OP_HALT  = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_IN_WAIT  = 3'd3,
        ST_OUT_WAIT = 3'd4,
        ST_HALT     = 3'd5
`ifdef BF_SINGLE_STEP_EN
        , ST_PAUSE  = 3'd6
`endif
    } seq_state_e;

endpackage

// File: rtl/bf_exec_sequencer_if.sv
// Instruction-fetch and byte-stream handshakes between the bf sequencer (master)
// and the instruction memory / I/O endpoints (slave).
interface bf_exec_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int PC_W  = 10
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output imem_req, imem_addr, in_ready, out_valid,
        input  imem_ack, imem_rdata, in_valid, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, in_ready, out_valid,
        output imem_ack, imem_rdata, in_valid, out_ready
    );
endinterface

// File: rtl/bf_exec_sequencer.sv
// bf CPU fetch/execute sequencer: owns the PC, the fetch handshake, the I/O stalls
// and the single-cycle datapath commit strobe. BF_SINGLE_STEP_EN adds a step input.
module bf_exec_sequencer
    import bf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
`ifdef BF_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                busy,
    output logic                halted,
    output logic                overflow,
    bf_exec_sequencer_if.master bus,
    output logic [WIDTH-1:0]    instruction,
    input  logic                dec_inp_gate,
    input  logic                dec_out_load,
    input  logic                dec_prc_load,
    input  logic [PC_W-1:0]     jump_addr,
    output logic                dp_commit,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [PC_W-1:0]  PC_MAX  = {PC_W{1'b1}};
    localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef BF_SINGLE_STEP_EN
    localparam seq_state_e ST_ADV = ST_PAUSE;
`else
    localparam seq_state_e ST_ADV = ST_FETCH;
`endif

    seq_state_e       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             commit_s;
    logic             in_ready_s;
    logic             clr_s;
    logic             at_end_s;
    logic [PC_W-1:0]  pc_next_s;

    // PC advance target; the last address without a jump ends the program.
    always_comb begin
        at_end_s  = (!dec_prc_load) && (pc_q == PC_MAX);
        if (dec_prc_load) begin
            pc_next_s = jump_addr;
        end else begin
            pc_next_s = pc_q + PC_ONE;
        end
    end

    // Sequencer next-state, commit strobe and PC/instruction next values.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        ovf_d      = ovf_q;
        commit_s   = 1'b0;
        in_ready_s = 1'b0;
        clr_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = {PC_W{1'b0}};
                    ovf_d   = 1'b0;
                    clr_s   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    if (bus.imem_rdata == {WIDTH{1'b0}}) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (dec_inp_gate) begin
                    state_d = ST_IN_WAIT;
                end else begin
                    commit_s = 1'b1;
                    if (dec_out_load) begin
                        state_d = ST_OUT_WAIT;
                    end else if (at_end_s) begin
                        ovf_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_next_s;
                        state_d = ST_ADV;
                    end
                end
            end
            ST_IN_WAIT: begin
                if (bus.in_valid) begin
                    commit_s   = 1'b1;
                    in_ready_s = 1'b1;
                    if (at_end_s) begin
                        ovf_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_next_s;
                        state_d = ST_ADV;
                    end
                end else begin
                    state_d = ST_IN_WAIT;
                end
            end
            // The output byte was committed on EXEC; only the send waits here.
            ST_OUT_WAIT: begin
                if (bus.out_ready) begin
                    if (at_end_s) begin
                        ovf_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = pc_next_s;
                        state_d = ST_ADV;
                    end
                end else begin
                    state_d = ST_OUT_WAIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef BF_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Retired-instruction counter: cleared on start, saturates at all ones.
    always_comb begin
        if (clr_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (commit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath-control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= {PC_W{1'b0}};
            instr_q <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (state_q == ST_OUT_WAIT);
    assign bus.in_ready  = in_ready_s;
    assign dp_commit     = commit_s;
    assign instruction   = instr_q;
    assign instr_count   = cnt_q;
    assign overflow      = ovf_q;
    assign halted        = (state_q == ST_HALT);
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_bf_exec_sequencer.sv
// Directed self-checking bench for bf_exec_sequencer: a 10-bit-PC instance for
// program tests and a 2-bit-PC instance for the PC overflow case.
module tb_bf_exec_sequencer;
    import bf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic step = 1'b0;
    logic jmp_en = 1'b0;
    logic [9:0] jump_addr = 10'd0;
    logic [7:0] mem [0:1023];

    logic busy, halted, overflow, dp_commit;
    logic [7:0] instruction;
    logic [15:0] instr_count;
    logic dec_inp_gate, dec_out_load, dec_prc_load;

    logic busy2, halted2, overflow2, dp_commit2;
    logic [7:0] instruction2;
    logic [15:0] instr_count2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_commit = 0, n_inrdy = 0, n_both = 0, n_ov = 0, last_commit = 0, commit_gap = 0;
    int s_commit, s_inrdy, s_both, s_ov;

    bf_exec_sequencer_if #(.WIDTH(8), .PC_W(10)) bus ();
    bf_exec_sequencer_if #(.WIDTH(8), .PC_W(2))  bus2 ();

    bf_exec_sequencer #(.WIDTH(8), .PC_W(10), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef BF_SINGLE_STEP_EN
        .step(step),
`endif
        .busy(busy), .halted(halted), .overflow(overflow), .bus(bus),
        .instruction(instruction), .dec_inp_gate(dec_inp_gate),
        .dec_out_load(dec_out_load), .dec_prc_load(dec_prc_load),
        .jump_addr(jump_addr), .dp_commit(dp_commit), .instr_count(instr_count)
    );

    bf_exec_sequencer #(.WIDTH(8), .PC_W(2), .CNT_W(16)) u_ovf (
        .clk(clk), .rst(rst), .start(start2),
`ifdef BF_SINGLE_STEP_EN
        .step(step),
`endif
        .busy(busy2), .halted(halted2), .overflow(overflow2), .bus(bus2),
        .instruction(instruction2), .dec_inp_gate(1'b0),
        .dec_out_load(1'b0), .dec_prc_load(1'b0),
        .jump_addr(2'd0), .dp_commit(dp_commit2), .instr_count(instr_count2)
    );

    always #5 clk = ~clk;

    // Zero-latency memories and a minimal decoder for the opcodes under test.
    always_comb begin
        bus.imem_ack    = bus.imem_req;
        bus.imem_rdata  = mem[bus.imem_addr];
        bus2.imem_ack   = bus2.imem_req;
        bus2.imem_rdata = OP_INC;
        bus2.in_valid   = 1'b0;
        bus2.out_ready  = 1'b0;
        dec_inp_gate    = (instruction == OP_IN);
        dec_out_load    = (instruction == OP_OUT);
        dec_prc_load    = jmp_en && (instruction == OP_END);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (dp_commit) begin
            n_commit    <= n_commit + 1;
            commit_gap  <= cyc - last_commit;
            last_commit <= cyc;
        end
        if (bus.in_ready) n_inrdy <= n_inrdy + 1;
        if (bus.in_ready && dp_commit) n_both <= n_both + 1;
        if (bus.out_valid) n_ov <= n_ov + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        jmp_en = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic start_run();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic snap();
        @(negedge clk);
        @(negedge clk);
        s_commit = n_commit;
        s_inrdy  = n_inrdy;
        s_both   = n_both;
        s_ov     = n_ov;
    endtask

    task automatic wait_halt(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, bus.out_valid}, 32'd1);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_commit", {31'd0, dp_commit}, 32'd0);
        check("rst_count", {16'd0, instr_count}, 32'd0);
        check("rst_ovf2", {31'd0, overflow2}, 32'd0);
        #1 rst = 1'b0;

        // "+ + halt": two commits two cycles apart, then HALT at pc 2
        mem[0] = OP_INC; mem[1] = OP_INC; mem[2] = OP_HALT;
        snap();
        start_run();
        wait_halt("p1_halted");
        check("p1_commits", n_commit - s_commit, 32'd2);
        check("p1_gap", commit_gap, 32'd2);
        check("p1_count", {16'd0, instr_count}, 32'd2);
        check("p1_pc", {22'd0, bus.imem_addr}, 32'd2);
        check("p1_busy", {31'd0, busy}, 32'd0);
        start_run();
        @(negedge clk);
        check("p1_start_ignored", {31'd0, halted}, 32'd1);
        check("p1_count_hold", {16'd0, instr_count}, 32'd2);

        // ",": input stall, single in_ready/commit pulse, pc 0 -> 1
        do_reset();
        mem[0] = OP_IN; mem[1] = OP_HALT;
        snap();
        start_run();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("p2_stall_commit", n_commit - s_commit, 32'd0);
        check("p2_stall_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        wait_halt("p2_halted");
        check("p2_inrdy", n_inrdy - s_inrdy, 32'd1);
        check("p2_commits", n_commit - s_commit, 32'd1);
        check("p2_same_cycle", n_both - s_both, 32'd1);
        check("p2_pc", {22'd0, bus.imem_addr}, 32'd1);
        check("p2_count", {16'd0, instr_count}, 32'd1);

        // ".": out_ready low 3 cycles -> out_valid held 4 cycles
        do_reset();
        mem[0] = OP_OUT; mem[1] = OP_HALT;
        snap();
        start_run();
        wait_out_valid("p3_out_valid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("p3_valid_4th", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("p3_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        check("p3_next_req", {31'd0, bus.imem_req}, 32'd1);
        check("p3_next_addr", {22'd0, bus.imem_addr}, 32'd1);
        wait_halt("p3_halted");
        check("p3_ov_cycles", n_ov - s_ov, 32'd4);
        check("p3_commits", n_commit - s_commit, 32'd1);

        // "]" at pc 7 with jump to 3
        do_reset();
        for (int i = 0; i < 7; i++) mem[i] = OP_INC;
        mem[7] = OP_END;
        jmp_en = 1'b1;
        jump_addr = 10'd3;
        start_run();
        n = 0;
        @(negedge clk);
        while (!(bus.imem_req && bus.imem_addr == 10'd7) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("p4_reach7", {22'd0, bus.imem_addr}, 32'd7);
        check("p4_count7", {16'd0, instr_count}, 32'd7);
        @(negedge clk);
        check("p4_commit", {31'd0, dp_commit}, 32'd1);
        @(negedge clk);
        check("p4_jump_addr", {22'd0, bus.imem_addr}, 32'd3);
        check("p4_count8", {16'd0, instr_count}, 32'd8);

        // PC_W=2, "++++" with no terminator: overflow halt at pc 3
        @(posedge clk); #1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!halted2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("p5_halted", {31'd0, halted2}, 32'd1);
        check("p5_overflow", {31'd0, overflow2}, 32'd1);
        check("p5_pc", {30'd0, bus2.imem_addr}, 32'd3);
        check("p5_count", {16'd0, instr_count2}, 32'd4);

        // reset in OUT_WAIT, then restart from address 0
        do_reset();
        mem[0] = OP_OUT;
        start_run();
        wait_out_valid("p6_in_out_wait");
        rst = 1'b1;
        #1;
        check("p6_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("p6_req", {31'd0, bus.imem_req}, 32'd0);
        check("p6_busy", {31'd0, busy}, 32'd0);
        check("p6_instr", {24'd0, instruction}, 32'd0);
        check("p6_count", {16'd0, instr_count}, 32'd0);
        check("p6_ovf2", {31'd0, overflow2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        start_run();
        @(negedge clk);
        check("p6_restart_req", {31'd0, bus.imem_req}, 32'd1);
        check("p6_restart_addr", {22'd0, bus.imem_addr}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bf_exec_sequencer.md
Name: bf_exec_sequencer

Overview:
- Fetch/execute sequencer for the bf CPU; owns the program counter, the instruction-memory fetch handshake and the byte-stream I/O handshakes.
- Presents one instruction at a time to the instruction decoder and issues a single-cycle commit strobe that qualifies every datapath register/RAM load.
- Stalls the datapath on memory latency, empty input or blocked output, and halts on a terminator byte or PC overflow.

Parameters:
- WIDTH, 8, instruction byte width.
- PC_W, 10, program counter / instruction address width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin execution from address 0; sampled only in IDLE.
- busy  output  1  high in any state except IDLE and HALT.
- halted  output  1  high in HALT.
- overflow  output  1  sticky; set when PC increments past 2^PC_W-1.
- imem_req  output  1  fetch request; held until imem_ack.
- imem_addr  output  PC_W  fetch address (equals pc).
- imem_ack  input  1  fetch data valid this cycle.
- imem_rdata  input  WIDTH  fetched byte.
- instruction  output  WIDTH  latched instruction to the decoder.
- dec_inp_gate  input  1  decoder: current instruction consumes input.
- dec_out_load  input  1  decoder: current instruction produces output.
- dec_prc_load  input  1  decoder: take jump.
- jump_addr  input  PC_W  jump target from the stack RAM.
- dp_commit  output  1  one-cycle strobe enabling all datapath loads.
- in_valid  input  1  input byte available.
- in_ready  output  1  input byte consumed (equals dp_commit for input).
- out_valid  output  1  output register holds a byte to send.
- out_ready  input  1  sink accepts the byte.
- instr_count  output  CNT_W  retired instructions, saturating.

Behaviour:
- Reset: state=IDLE, pc=0, instruction=0, instr_count=0, overflow=0. All strobes (imem_req, dp_commit, in_ready, out_valid) are 0. Reset mid-operation abandons any fetch or I/O immediately.
- States: IDLE, FETCH, EXEC, IN_WAIT, OUT_WAIT, HALT.
- IDLE: on start go to FETCH with pc=0, instr_count=0, overflow=0.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch imem_rdata into instruction.
  - If imem_rdata==0x00, go to HALT with no commit.
  - Otherwise go to EXEC.
  - Minimum fetch latency is 1 cycle (ack in the request cycle).
- EXEC (decoder outputs are valid):
  - If dec_inp_gate: go to IN_WAIT with no commit.
  - Otherwise: dp_commit=1 this cycle. If dec_out_load, go to OUT_WAIT; else advance the PC and go to FETCH.
- IN_WAIT: when in_valid=1, dp_commit=1 and in_ready=1 for one cycle; advance the PC; go to FETCH.
- OUT_WAIT: out_valid=1 until out_ready=1. On handshake, drop out_valid, advance the PC, go to FETCH. Output is committed on EXEC entry and only the send is stalled.
- PC advance: pc <= dec_prc_load ? jump_addr : pc+1.
  - If pc==2^PC_W-1 and no jump: set overflow=1, go to HALT, leave pc unchanged.
- instr_count: +1 on every dp_commit; saturates at all ones.
- HALT: holds all state; only rst leaves it. start is ignored.
- Simultaneous in_valid with EXEC entry: no effect until IN_WAIT (adds one stall cycle by design).
- Throughput: 2 cycles per non-I/O instruction with zero-latency memory.

Optional Feature:
- Macro BF_SINGLE_STEP_EN.
- Defined: adds input step (1 bit) and state PAUSE. Every PC advance goes to PAUSE instead of FETCH. A one-cycle step pulse moves PAUSE to FETCH. busy stays 1 in PAUSE.
- Undefined: no step port, no PAUSE state; PC advance goes directly to FETCH.

Decomposition:
- Shared package bf_pkg holds:
  - Opcode constants: OP_INC 0x2B, OP_DEC 0x2D, OP_RIGHT 0x3E, OP_LEFT 0x3C, OP_OUT 0x2E, OP_IN 0x2C, OP_LOOP 0x5B, OP_END 0x5D, OP_HALT 0x00.
  - The sequencer state enum.
- No sub-module; the FSM and PC/counter logic stay in one module.

Test Plan:
- Program "+ + 0x00", zero-latency ack → two dp_commit pulses 2 cycles apart; halted=1; instr_count=2; pc=2.
- "," with in_valid low for 5 cycles then high → in_ready and dp_commit asserted in one cycle only; PC advances from 0 to 1.
- "." with out_ready low 3 cycles → out_valid held 4 cycles; dp_commit exactly once; next fetch at addr 1.
- "]" at pc=7 with dec_prc_load=1, jump_addr=3 → next imem_addr=3; instr_count increments by 1.
- PC_W=2, memory "++++" with no terminator → overflow=1, halted=1, pc=3, instr_count=4.
- Assert rst during OUT_WAIT → all outputs at reset values next cycle; start restarts fetch at addr 0.
